// File: rtl/l2_arbiter.sv
// l2_arbiter: serialises I-cache and D-cache line traffic onto one L2 port, returning fills through a line buffer.
// Define L2_ARBITER_FAIR_EN to alternate grants when both caches request together (default: D over I).
module l2_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic                  arb_busy,
  output logic                  grant_d
);
  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;
  state_t state, state_nxt;
  logic [LINE_WIDTH-1:0] line_q;
  logic grant_q;
  logic d_req, pick_d, serve_i, serve_d, resp_i, resp_d;
  assign d_req = d_pmem_read | d_pmem_write;
`ifdef L2_ARBITER_FAIR_EN
  // grant_q doubles as the last-grant record: on a tie the side not served last wins
  assign pick_d = d_req & (~i_pmem_read | ~grant_q);
`else
  assign pick_d = d_req;
`endif
  assign serve_i = state == SERVE_I;
  assign serve_d = state == SERVE_D;
  assign resp_i  = state == RESP_I;
  assign resp_d  = state == RESP_D;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = pick_d ? SERVE_D : i_pmem_read ? SERVE_I : IDLE;
      SERVE_I: state_nxt = l2_resp ? RESP_I : SERVE_I;
      SERVE_D: state_nxt = l2_resp ? RESP_D : SERVE_D;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      line_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((serve_i | serve_d) & l2_resp) line_q <= l2_rdata;
      if (state == IDLE && state_nxt != IDLE) grant_q <= state_nxt == SERVE_D;
    end
  end
  assign l2_read      = serve_i | (serve_d & d_pmem_read & ~d_pmem_write);
  assign l2_write     = serve_d & d_pmem_write;
  assign l2_address   = serve_i ? i_pmem_address : serve_d ? d_pmem_address : '0;
  assign l2_wdata     = serve_d ? d_pmem_wdata : '0;
  assign i_pmem_resp  = resp_i;
  assign d_pmem_resp  = resp_d;
  assign i_pmem_rdata = resp_i ? line_q : '0;
  assign d_pmem_rdata = resp_d ? line_q : '0;
  assign arb_busy     = state != IDLE;
  assign grant_d      = grant_q;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed table, hand sequences and random rounds against a transaction-level grant model.
module tb_l2_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_pmem_read = 1'b0;
  logic [15:0]  i_pmem_address = '0;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [15:0]  d_pmem_address = '0;
  logic [127:0] d_pmem_wdata = '0;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata = '0;
  logic         l2_resp = 1'b0;
  logic         arb_busy;
  logic         grant_d;
  int checks = 0;
  int errors = 0;
  bit last_d = 1'b0;

  l2_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .arb_busy(arb_busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit i, dr, dw;
    logic [15:0] ia, da;
    logic [127:0] wd;
    int dl;
    logic [127:0] rd;
    bit exp_rd, exp_wr;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, arb_busy, 0);
    chk({tag, " l2_read"}, l2_read, 0);
    chk({tag, " l2_write"}, l2_write, 0);
    chk({tag, " l2_address"}, l2_address, 0);
    chk({tag, " l2_wdata"}, l2_wdata, 0);
    chk({tag, " i_resp"}, i_pmem_resp, 0);
    chk({tag, " d_resp"}, d_pmem_resp, 0);
    chk({tag, " i_rdata"}, i_pmem_rdata, 0);
    chk({tag, " d_rdata"}, d_pmem_rdata, 0);
  endtask

  // Starting in IDLE with requests held: one full grant, L2 transfer and response.
  task automatic serve(input bit is_d, input bit exp_rd, input bit exp_wr, input int delay, input logic [127:0] data);
    tick;
    chk("serve busy", arb_busy, 1);
    chk("serve grant_d", grant_d, is_d);
    chk("serve l2_read", l2_read, exp_rd);
    chk("serve l2_write", l2_write, exp_wr);
    chk("serve l2_address", l2_address, is_d ? d_pmem_address : i_pmem_address);
    chk("serve l2_wdata", l2_wdata, is_d ? d_pmem_wdata : 128'd0);
    repeat (delay) begin
      tick;
      chk("wait resp", {i_pmem_resp, d_pmem_resp, arb_busy}, 3'b001);
    end
    l2_resp = 1'b1;
    l2_rdata = data;
    tick;
    l2_resp = 1'b0;
    l2_rdata = {$urandom, $urandom, $urandom, $urandom};
    chk("i_resp", i_pmem_resp, !is_d);
    chk("d_resp", d_pmem_resp, is_d);
    chk("i_rdata", i_pmem_rdata, is_d ? 128'd0 : data);
    chk("d_rdata", d_pmem_rdata, is_d ? data : 128'd0);
    chk("resp l2 idle", {l2_read, l2_write}, 2'b00);
    if (is_d) begin
      d_pmem_read = 1'b0;
      d_pmem_write = 1'b0;
    end else i_pmem_read = 1'b0;
    tick;
    chk("post resp", {i_pmem_resp, d_pmem_resp, arb_busy, l2_read, l2_write}, 5'b0);
    chk("post grant hold", grant_d, is_d);
  endtask

  // Reference grant rule: D wins ties unless fairness says the side served last yields.
  task automatic round(input bit i, input bit dr, input bit dw, input logic [15:0] ia, input logic [15:0] da,
                       input logic [127:0] wd, input int dl0, input int dl1, input logic [127:0] r0, input logic [127:0] r1);
    bit dp, first_d;
    dp = dr | dw;
    i_pmem_read = i;
    i_pmem_address = ia;
    d_pmem_read = dr;
    d_pmem_write = dw;
    d_pmem_address = da;
    d_pmem_wdata = wd;
`ifdef L2_ARBITER_FAIR_EN
    first_d = dp && (!i || !last_d);
`else
    first_d = dp;
`endif
    serve(first_d, first_d ? (dr && !dw) : 1'b1, first_d && dw, dl0, r0);
    last_d = first_d;
    if (i && dp) begin
      serve(!first_d, first_d ? 1'b1 : (dr && !dw), !first_d && dw, dl1, r1);
      last_d = !first_d;
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, 128'd0, 2, {16{8'hA5}}, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000, 128'h0123456789ABCDEF0123456789ABCDEF, 0, 128'h5A, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 128'hDEAD, 1, {4{32'hCAFEF00D}}, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h7777, {4{32'h11112222}}, 3, 128'h1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 128'd0, 0, {128{1'b1}}, 1'b1, 1'b0};
    #12;
    chk_idle("reset");
    chk("reset grant_d", grant_d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk_idle("after reset");
    for (int n = 0; n < 5; n++) begin
      i_pmem_read = tbl[n].i;
      i_pmem_address = tbl[n].ia;
      d_pmem_read = tbl[n].dr;
      d_pmem_write = tbl[n].dw;
      d_pmem_address = tbl[n].da;
      d_pmem_wdata = tbl[n].wd;
      serve(tbl[n].dr | tbl[n].dw, tbl[n].exp_rd, tbl[n].exp_wr, tbl[n].dl, tbl[n].rd);
      last_d = tbl[n].dr | tbl[n].dw;
    end
    for (int n = 0; n < 3; n++)
      round(1'b1, 1'b1, 1'b0, 16'h0100 + 16'(n), 16'h0200 + 16'(n), 128'd0, n, 2 - n,
            {4{$urandom}}, {4{$urandom}});
    l2_resp = 1'b1;
    l2_rdata = {4{32'h99999999}};
    tick;
    l2_resp = 1'b0;
    chk_idle("stray resp");
    tick;
    chk_idle("stray resp next");
    d_pmem_write = 1'b1;
    d_pmem_address = 16'h4444;
    d_pmem_wdata = {4{32'h87654321}};
    tick;
    chk("pre-reset l2_write", l2_write, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async reset");
    chk("async reset grant_d", grant_d, 0);
    d_pmem_write = 1'b0;
    last_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    l2_resp = 1'b1;
    l2_rdata = {4{32'h31415926}};
    tick;
    l2_resp = 1'b0;
    chk_idle("late l2_resp");
    tick;
    chk_idle("late l2_resp next");
    for (int n = 0; n < 40; n++) begin
      bit ri, rr, rw;
      ri = 1'($urandom);
      rr = 1'($urandom);
      rw = 1'($urandom);
      if (!ri && !rr && !rw) ri = 1'b1;
      round(ri, rr, rw, 16'($urandom), 16'($urandom), {4{$urandom}},
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), {4{$urandom}}, {4{$urandom}});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
